// File: rtl/exe_div_pkg.sv
// Shared definitions for the iterative execute-stage divider: state encoding,
// default geometry and the conditional two's complement helper.
package exe_div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DIV_WIDTH_DEF = 32;
    localparam int DIV_BPC_DEF   = 1;
    localparam int DIV_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CALC = S_CALC,
        ST_DONE = S_DONE
    } div_state_t;

    // Negation only propagates carries upward, so the low bits of the result are
    // correct for any operand width up to DIV_MAX_WIDTH once truncated.
    function automatic logic [DIV_MAX_WIDTH-1:0] cond_neg(
        input logic [DIV_MAX_WIDTH-1:0] value,
        input logic                     neg
    );
        logic [DIV_MAX_WIDTH-1:0] res;
        if (neg) begin
            res = ~value + {{(DIV_MAX_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/exe_div_step.sv
// One restoring division step: shift one dividend bit into the partial
// remainder, trial-subtract the divisor and emit one quotient bit.
module exe_div_step
    import exe_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem_hi_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_hi_out,
    output logic             q_bit
);

    logic [WIDTH:0] ext_s;
    logic [WIDTH:0] diff_s;

    // The shifted remainder needs WIDTH+1 bits; a borrow in the top bit means it is below the divisor.
    assign ext_s      = {rem_hi_in, next_bit};
    assign diff_s     = ext_s - {1'b0, divisor};
    assign q_bit      = ~diff_s[WIDTH];
    assign rem_hi_out = q_bit ? diff_s[WIDTH-1:0] : ext_s[WIDTH-1:0];

endmodule

// File: rtl/exe_iter_div.sv
// Iterative signed/unsigned divider (LoongArch DIV/MOD semantics), BPC quotient bits per cycle.
// Optional EXE_DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module exe_iter_div
    import exe_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int BPC   = DIV_BPC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    localparam int              N        = WIDTH / BPC;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(N - 1);

    div_state_t             state_r;
    logic [2*WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]       div_mag_r;
    logic [WIDTH-1:0]       cnt_r;
    logic                   sq_r;
    logic                   sr_r;
    logic [WIDTH-1:0]       quotient_r;
    logic [WIDTH-1:0]       remainder_r;

    logic                   a_neg_s;
    logic                   b_neg_s;
    logic [WIDTH-1:0]       a_mag_s;
    logic [WIDTH-1:0]       b_mag_s;
    logic                   early_s;
    logic [WIDTH-1:0]       q_fin_s;
    logic [WIDTH-1:0]       r_fin_s;
    logic [BPC:0][2*WIDTH-1:0] chain_s;

    assign a_neg_s = in_signed & dividend[WIDTH-1];
    assign b_neg_s = in_signed & divisor[WIDTH-1];
    assign a_mag_s = WIDTH'(cond_neg(DIV_MAX_WIDTH'(dividend), a_neg_s));
    assign b_mag_s = WIDTH'(cond_neg(DIV_MAX_WIDTH'(divisor), b_neg_s));

`ifdef EXE_DIV_EARLY_OUT_EN
    assign early_s = (a_mag_s < b_mag_s);
`else
    assign early_s = 1'b0;
`endif

    // Upper half holds the partial remainder, lower half the unconsumed dividend bits / quotient.
    assign chain_s[0] = rem_r;

    for (genvar g = 0; g < BPC; g++) begin : g_step
        logic [WIDTH-1:0] hi_s;
        logic             qb_s;

        exe_div_step #(.WIDTH(WIDTH)) u_step (
            .rem_hi_in  (chain_s[g][2*WIDTH-1:WIDTH]),
            .next_bit   (chain_s[g][WIDTH-1]),
            .divisor    (div_mag_r),
            .rem_hi_out (hi_s),
            .q_bit      (qb_s)
        );

        assign chain_s[g+1] = {hi_s, chain_s[g][WIDTH-2:0], qb_s};
    end

    assign q_fin_s = WIDTH'(cond_neg(DIV_MAX_WIDTH'(chain_s[BPC][WIDTH-1:0]), sq_r));
    assign r_fin_s = WIDTH'(cond_neg(DIV_MAX_WIDTH'(chain_s[BPC][2*WIDTH-1:WIDTH]), sr_r));

    // Control FSM with operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rem_r       <= {(2*WIDTH){1'b0}};
            div_mag_r   <= {WIDTH{1'b0}};
            cnt_r       <= {WIDTH{1'b0}};
            sq_r        <= 1'b0;
            sr_r        <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        sq_r      <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sr_r      <= a_neg_s;
                        rem_r     <= {{WIDTH{1'b0}}, a_mag_s};
                        div_mag_r <= b_mag_s;
                        cnt_r     <= CNT_LAST;
                        if (divisor == {WIDTH{1'b0}}) begin
                            state_r     <= ST_DONE;
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                        end else if (early_s) begin
                            state_r     <= ST_DONE;
                            quotient_r  <= {WIDTH{1'b0}};
                            remainder_r <= dividend;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r <= chain_s[BPC];
                    cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
                    if (cnt_r == {WIDTH{1'b0}}) begin
                        state_r     <= ST_DONE;
                        quotient_r  <= q_fin_s;
                        remainder_r <= r_fin_s;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE) && !flush;
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r != ST_IDLE);
    assign quotient  = quotient_r;
    assign remainder = remainder_r;

endmodule

// File: tb/tb_exe_iter_div.sv
// Directed bench for exe_iter_div: a BPC=1 and a BPC=2 instance share all stimulus.
module tb_exe_iter_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_ready;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] quotient1, remainder1;
    logic        in_ready2, out_valid2, busy2;
    logic [31:0] quotient2, remainder2;

    int checks = 0;
    int errors = 0;
    int lat1;
    int lat2;

`ifdef EXE_DIV_EARLY_OUT_EN
    localparam int EO_LAT1 = 1;
    localparam int EO_LAT2 = 1;
`else
    localparam int EO_LAT1 = 33;
    localparam int EO_LAT2 = 17;
`endif

    exe_iter_div #(.WIDTH(32), .BPC(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_signed(in_signed),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid1), .out_ready(out_ready),
        .quotient(quotient1), .remainder(remainder1), .busy(busy1)
    );

    exe_iter_div #(.WIDTH(32), .BPC(2)) u_dut2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_signed(in_signed),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid2), .out_ready(out_ready),
        .quotient(quotient2), .remainder(remainder2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Issue one op, scramble the inputs afterwards, record cycles until each out_valid (0 = timeout).
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        in_signed = s;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_signed = ~s;
        dividend  = ~a;
        divisor   = b ^ 32'h5A5A_5A5A;
        lat1 = 0;
        lat2 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (lat1 == 0 && out_valid1) lat1 = c;
            if (lat2 == 0 && out_valid2) lat2 = c;
            if (lat1 != 0 && lat2 != 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
        checks++; if (quotient1 !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient1); end
        checks++; if (remainder1 !== 32'h0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder1); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
        checks++; if (in_ready2 !== 1'b1 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 got ready %b busy %b want 1 0", in_ready2, busy2); end
    endtask

    task automatic test_signed_unsigned();
        logic        vs [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] va [5] = '{32'h0000_0007, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1000};
        logic [31:0] vb [5] = '{32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0010, 32'd3};
        logic [31:0] vq [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0FFF_FFFF, 32'd333};
        logic [31:0] vr [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_000F, 32'd1};
        for (int i = 0; i < 5; i++) begin
            run_op(vs[i], va[i], vb[i]);
            checks++; if (lat1 !== 33) begin errors++; $display("FAIL div%0d_lat1 got %0d want 33", i, lat1); end
            checks++; if (lat2 !== 17) begin errors++; $display("FAIL div%0d_lat2 got %0d want 17", i, lat2); end
            checks++; if (quotient1 !== vq[i]) begin errors++; $display("FAIL div%0d_q1 got %h want %h", i, quotient1, vq[i]); end
            checks++; if (remainder1 !== vr[i]) begin errors++; $display("FAIL div%0d_r1 got %h want %h", i, remainder1, vr[i]); end
            checks++; if (quotient2 !== vq[i]) begin errors++; $display("FAIL div%0d_q2 got %h want %h", i, quotient2, vq[i]); end
            checks++; if (remainder2 !== vr[i]) begin errors++; $display("FAIL div%0d_r2 got %h want %h", i, remainder2, vr[i]); end
            consume();
        end
    endtask

    task automatic test_div_zero();
        for (int s = 0; s < 2; s++) begin
            run_op(s[0], 32'h0000_1234, 32'h0);
            checks++; if (lat1 !== 1 || lat2 !== 1) begin errors++; $display("FAIL dz%0d_lat got %0d/%0d want 1/1", s, lat1, lat2); end
            checks++; if (quotient1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz%0d_q1 got %h want ffffffff", s, quotient1); end
            checks++; if (remainder1 !== 32'h0000_1234) begin errors++; $display("FAIL dz%0d_r1 got %h want 00001234", s, remainder1); end
            checks++; if (quotient2 !== 32'hFFFF_FFFF || remainder2 !== 32'h0000_1234) begin errors++; $display("FAIL dz%0d_dut2 got %h %h want ffffffff 00001234", s, quotient2, remainder2); end
            consume();
        end
    endtask

    task automatic test_flush();
        logic seen;
        in_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL flush_busy got %b/%b want 0/0", busy1, busy2); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid1); end
        @(posedge clk); #1;
        checks++; if (in_ready1 !== 1'b1 || in_ready2 !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b/%b want 1/1", in_ready1, in_ready2); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid1 || out_valid2) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got %b want 0", seen); end
        run_op(1'b0, 32'd100, 32'd7);
        checks++; if (lat1 !== 33 || lat2 !== 17) begin errors++; $display("FAIL after_flush_lat got %0d/%0d want 33/17", lat1, lat2); end
        checks++; if (quotient1 !== 32'd14 || remainder1 !== 32'd2) begin errors++; $display("FAIL after_flush_dut1 got %0d r %0d want 14 r 2", quotient1, remainder1); end
        checks++; if (quotient2 !== 32'd14 || remainder2 !== 32'd2) begin errors++; $display("FAIL after_flush_dut2 got %0d r %0d want 14 r 2", quotient2, remainder2); end
        consume();
    endtask

    task automatic test_reset_mid();
        logic seen;
        in_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (quotient1 !== 32'h0 || remainder1 !== 32'h0) begin errors++; $display("FAIL rmid_clear got %h %h want 0 0", quotient1, remainder1); end
        checks++; if (busy1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL rmid_idle got busy %b ready %b want 0 1", busy1, in_ready1); end
        checks++; if (quotient2 !== 32'h0 || busy2 !== 1'b0) begin errors++; $display("FAIL rmid_dut2 got q %h busy %b want 0 0", quotient2, busy2); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid1 || out_valid2) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_result got %b want 0", seen); end
    endtask

    task automatic test_hold();
        run_op(1'b0, 32'd1000, 32'd3);
        checks++; if (lat1 !== 33) begin errors++; $display("FAIL hold_lat got %0d want 33", lat1); end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL hold%0d_valid got %b want 1", k, out_valid1); end
            checks++; if (quotient1 !== 32'd333 || remainder1 !== 32'd1) begin errors++; $display("FAIL hold%0d_data got %0d r %0d want 333 r 1", k, quotient1, remainder1); end
            checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got %b want 0", k, in_ready1); end
        end
        out_ready = 1'b1; in_valid = 1'b1; in_signed = 1'b0; dividend = 32'd5; divisor = 32'd1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (busy1 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL hold_release got busy %b valid %b want 0 0", busy1, out_valid1); end
        checks++; if (busy2 !== 1'b0 || in_ready1 !== 1'b1) begin errors++; $display("FAIL hold_no_accept got busy2 %b ready1 %b want 0 1", busy2, in_ready1); end
        flush = 1'b1; in_valid = 1'b1;
        #1;
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got %b want 0", in_ready1); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL flush_idle_accept got %b/%b want 0/0", busy1, busy2); end
    endtask

    task automatic test_early_out();
        logic        vs [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] va [3] = '{32'd3, 32'hFFFF_FFFD, 32'd0};
        logic [31:0] vb [3] = '{32'd10, 32'd10, 32'd5};
        logic [31:0] vr [3] = '{32'd3, 32'hFFFF_FFFD, 32'd0};
        for (int i = 0; i < 3; i++) begin
            run_op(vs[i], va[i], vb[i]);
            checks++; if (lat1 !== EO_LAT1 || lat2 !== EO_LAT2) begin errors++; $display("FAIL eo%0d_lat got %0d/%0d want %0d/%0d", i, lat1, lat2, EO_LAT1, EO_LAT2); end
            checks++; if (quotient1 !== 32'h0 || remainder1 !== vr[i]) begin errors++; $display("FAIL eo%0d_dut1 got %h r %h want 0 r %h", i, quotient1, remainder1, vr[i]); end
            checks++; if (quotient2 !== 32'h0 || remainder2 !== vr[i]) begin errors++; $display("FAIL eo%0d_dut2 got %h r %h want 0 r %h", i, quotient2, remainder2, vr[i]); end
            consume();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        dividend = 32'h0; divisor = 32'h0; out_ready = 1'b0;
        test_reset();
        test_signed_unsigned();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_hold();
        test_early_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
